traffic_light_monitor: RTL and testbench

Reader/checker for the 8-bit intersection light bus produced by the traffic light controller.
- Samples the bus every clock and decodes the four 2-bit direction fields.
- Verifies that the light sequence is legal and safe, latches the first violation, and reports the active direction and a count of green phases served.
- Sits beside the controller as a safety watchdog; its fault output is intended to force flashing/all-red upstream.

---
 rtl/traffic_light_monitor.sv | 251 +++++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Purpose: safety watchdog that decodes the 8-bit intersection light bus and latches the first violation.
// Latency: 1 cycle; the bus sampled at edge k appears on every output after edge k.
// Backpressure: none; the bus is sampled every clock and there is no handshake.
//
// Ports:
//   clk                  - system clock, rising edge
//   rst                  - synchronous active-high reset; wins over fault_clr and all monitoring
//   lightOfTrafficLights - {W[7:6], E[5:4], S[3:2], N[1:0]}, per field 00=RED 01=YELLOW 10=GREEN 11=illegal
//   fault_clr            - one-cycle pulse that clears the latched fault
//   fault                - sticky fault flag
//   fault_code           - first latched violation (0 none, 1 ILLEGAL, 2 CONFLICT, 3 BAD_SEQ,
//                          4 SHORT_GREEN, 5 SHORT_YELLOW, 6 NO_ALLRED)
//   fault_dir            - direction of the latched violation (0=N 1=S 2=E 3=W)
//   active_dir           - direction currently showing non-red (valid when active_valid=1)
//   active_valid         - exactly one field is non-red and no field is illegal
//   phase_count          - saturating count of RED->GREEN starts since reset
module traffic_light_monitor #(
  parameter int unsigned MIN_GREEN   = 4,
  parameter int unsigned MIN_YELLOW  = 2,
  parameter int unsigned ALL_RED_MIN = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lightOfTrafficLights,
  input  logic             fault_clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [1:0]       fault_dir,
  output logic [1:0]       active_dir,
  output logic             active_valid,
  output logic [CNT_W-1:0] phase_count
);

  // Light field encodings
  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;
  localparam logic [1:0] L_ILL    = 2'b11;

  // Fault codes
  localparam logic [2:0] F_NONE         = 3'd0;
  localparam logic [2:0] F_ILLEGAL      = 3'd1;
  localparam logic [2:0] F_CONFLICT     = 3'd2;
  localparam logic [2:0] F_BAD_SEQ      = 3'd3;
  localparam logic [2:0] F_SHORT_GREEN  = 3'd4;
  localparam logic [2:0] F_SHORT_YELLOW = 3'd5;
  localparam logic [2:0] F_NO_ALLRED    = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam logic [CNT_W-1:0] MIN_GREEN_C   = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_YELLOW_C  = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] ALL_RED_MIN_C = CNT_W'(ALL_RED_MIN);

  // Lowest set index of a 4-bit direction vector (N has the highest priority).
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0][1:0]       prev_q, prev_d;
  // Dwell counters are kept per direction so a conflicting second field can
  // never corrupt the dwell time of the field that is legitimately active.
  logic [3:0][CNT_W-1:0] green_cnt_q, green_cnt_d;
  logic [3:0][CNT_W-1:0] yellow_cnt_q, yellow_cnt_d;
  logic [CNT_W-1:0]      allred_cnt_q, allred_cnt_d;
  logic [CNT_W-1:0]      phase_count_q, phase_count_d;
  logic                  fault_q, fault_d;
  logic [2:0]            fault_code_q, fault_code_d;
  logic [1:0]            fault_dir_q, fault_dir_d;
  logic [1:0]            active_dir_q, active_dir_d;
  logic                  active_valid_q, active_valid_d;

  // ---------------------------------------------------------------------------
  // Per-field decode and violation detection
  // ---------------------------------------------------------------------------
  logic [3:0][1:0] cur;
  logic [3:0]      ill_v;     // field shows 11
  logic [3:0]      nonred_v;  // field shows anything but RED (including 11)
  logic [3:0]      r2g_v;     // RED->GREEN start
  logic [3:0]      bad_v;     // transition outside the legal set
  logic [3:0]      sg_v;      // GREEN->YELLOW too early
  logic [3:0]      sy_v;      // YELLOW->RED too early
  logic [3:0]      nar_v;     // RED->GREEN without enough all-red time
  logic [2:0]      nonred_cnt;
  logic [2:0]      r2g_cnt;
  logic            all_red;

  always_comb begin
    cur        = '0;
    ill_v      = '0;
    nonred_v   = '0;
    r2g_v      = '0;
    bad_v      = '0;
    sg_v       = '0;
    sy_v       = '0;
    nar_v      = '0;
    nonred_cnt = '0;
    r2g_cnt    = '0;
    all_red    = (lightOfTrafficLights == 8'h00);
    for (int d = 0; d < 4; d++) begin
      cur[d]      = lightOfTrafficLights[2*d +: 2];
      ill_v[d]    = (cur[d] == L_ILL);
      nonred_v[d] = (cur[d] != L_RED);
      r2g_v[d]    = (prev_q[d] == L_RED) && (cur[d] == L_GREEN);
      case ({prev_q[d], cur[d]})
        {L_RED,    L_RED},
        {L_RED,    L_GREEN},
        {L_GREEN,  L_GREEN},
        {L_GREEN,  L_YELLOW},
        {L_YELLOW, L_YELLOW},
        {L_YELLOW, L_RED}:    bad_v[d] = 1'b0;
        // Anything touching 11 on either side is also a sequencing error.
        default:              bad_v[d] = 1'b1;
      endcase
      // Dwell counts are the values accumulated before this sample.
      sg_v[d]  = (prev_q[d] == L_GREEN)  && (cur[d] == L_YELLOW) && (green_cnt_q[d]  < MIN_GREEN_C);
      sy_v[d]  = (prev_q[d] == L_YELLOW) && (cur[d] == L_RED)    && (yellow_cnt_q[d] < MIN_YELLOW_C);
      nar_v[d] = r2g_v[d] && (allred_cnt_q < ALL_RED_MIN_C);
      nonred_cnt = nonred_cnt + 3'(nonred_v[d]);
      r2g_cnt    = r2g_cnt + 3'(r2g_v[d]);
    end
  end

  // ---------------------------------------------------------------------------
  // Violation priority: class order first, then lowest direction index.
  // ---------------------------------------------------------------------------
  logic       viol_vld;
  logic [2:0] viol_code;
  logic [1:0] viol_dir;

  always_comb begin
    viol_vld  = 1'b1;
    viol_code = F_NONE;
    viol_dir  = 2'd0;
    if (|ill_v) begin
      viol_code = F_ILLEGAL;
      viol_dir  = lowest_idx(ill_v);
    end else if (nonred_cnt >= 3'd2) begin
      viol_code = F_CONFLICT;
      viol_dir  = lowest_idx(nonred_v);
    end else if (|bad_v) begin
      viol_code = F_BAD_SEQ;
      viol_dir  = lowest_idx(bad_v);
    end else if (|sg_v) begin
      viol_code = F_SHORT_GREEN;
      viol_dir  = lowest_idx(sg_v);
    end else if (|sy_v) begin
      viol_code = F_SHORT_YELLOW;
      viol_dir  = lowest_idx(sy_v);
    end else if (|nar_v) begin
      viol_code = F_NO_ALLRED;
      viol_dir  = lowest_idx(nar_v);
    end else begin
      viol_vld  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [CNT_W:0] phase_sum;

  always_comb begin
    prev_d         = cur;
    green_cnt_d    = '0;
    yellow_cnt_d   = '0;
    allred_cnt_d   = all_red ? sat_inc(allred_cnt_q) : '0;
    fault_d        = fault_q;
    fault_code_d   = fault_code_q;
    fault_dir_d    = fault_dir_q;
    active_valid_d = 1'b0;
    active_dir_d   = active_dir_q;

    // A run restarts at 1 on entry and keeps counting while the code persists.
    for (int d = 0; d < 4; d++) begin
      if (cur[d] == L_GREEN)
        green_cnt_d[d] = (prev_q[d] == L_GREEN) ? sat_inc(green_cnt_q[d]) : CNT_W'(1);
      if (cur[d] == L_YELLOW)
        yellow_cnt_d[d] = (prev_q[d] == L_YELLOW) ? sat_inc(yellow_cnt_q[d]) : CNT_W'(1);
    end

    // Several simultaneous starts each count; widen by one bit to detect saturation.
    phase_sum     = {1'b0, phase_count_q} + (CNT_W+1)'(r2g_cnt);
    phase_count_d = phase_sum[CNT_W] ? CNT_MAX : phase_sum[CNT_W-1:0];

    // A new violation wins over a clear in the same cycle, so a clear can
    // never mask a fault that is still happening.
    if (viol_vld && (!fault_q || fault_clr)) begin
      fault_d      = 1'b1;
      fault_code_d = viol_code;
      fault_dir_d  = viol_dir;
    end else if (fault_clr) begin
      fault_d      = 1'b0;
      fault_code_d = F_NONE;
      fault_dir_d  = 2'd0;
    end

    if (!(|ill_v) && (nonred_cnt == 3'd1)) begin
      active_valid_d = 1'b1;
      active_dir_d   = lowest_idx(nonred_v);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q         <= {4{L_RED}};
      green_cnt_q    <= '0;
      yellow_cnt_q   <= '0;
      // Start saturated at the minimum so the first green after reset is legal.
      allred_cnt_q   <= ALL_RED_MIN_C;
      phase_count_q  <= '0;
      fault_q        <= 1'b0;
      fault_code_q   <= F_NONE;
      fault_dir_q    <= 2'd0;
      active_dir_q   <= 2'd0;
      active_valid_q <= 1'b0;
    end else begin
      prev_q         <= prev_d;
      green_cnt_q    <= green_cnt_d;
      yellow_cnt_q   <= yellow_cnt_d;
      allred_cnt_q   <= allred_cnt_d;
      phase_count_q  <= phase_count_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
      fault_dir_q    <= fault_dir_d;
      active_dir_q   <= active_dir_d;
      active_valid_q <= active_valid_d;
    end
  end

  assign fault        = fault_q;
  assign fault_code   = fault_code_q;
  assign fault_dir    = fault_dir_q;
  assign active_dir   = active_dir_q;
  assign active_valid = active_valid_q;
  assign phase_count  = phase_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Purpose: bench for traffic_light_monitor; directed scenarios followed by a biased random run.
// Latency: expects every output to reflect the bus one edge after it is sampled.
// Backpressure: none; one bus value is applied per clock.
module tb_traffic_light_monitor;

  localparam int MIN_GREEN   = 4;
  localparam int MIN_YELLOW  = 2;
  localparam int ALL_RED_MIN = 1;
  localparam int CNT_W       = 16;
  localparam int SAT         = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       bus = 8'h00;
  logic             fault_clr = 1'b0;
  logic             fault;
  logic [2:0]       fault_code;
  logic [1:0]       fault_dir;
  logic [1:0]       active_dir;
  logic             active_valid;
  logic [CNT_W-1:0] phase_count;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_GREEN  (MIN_GREEN),
    .MIN_YELLOW (MIN_YELLOW),
    .ALL_RED_MIN(ALL_RED_MIN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lightOfTrafficLights(bus),
    .fault_clr           (fault_clr),
    .fault               (fault),
    .fault_code          (fault_code),
    .fault_dir           (fault_dir),
    .active_dir          (active_dir),
    .active_valid        (active_valid),
    .phase_count         (phase_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each field remembers its last colour and how many samples
  // in a row it has shown that colour; the intersection remembers how long it
  // has been all red.
  int m_prev[4];
  int m_run[4];
  int m_allred;
  int m_fault, m_code, m_dir, m_adir, m_avalid, m_phase;

  function automatic void model_reset();
    for (int d = 0; d < 4; d++) begin
      m_prev[d] = 0;
      m_run[d]  = 0;
    end
    m_allred = ALL_RED_MIN;
    m_fault = 0; m_code = 0; m_dir = 0; m_adir = 0; m_avalid = 0; m_phase = 0;
  endfunction

  function automatic bit legal_move(int p, int c);
    return (p == c && c != 3) || (p == 0 && c == 2) || (p == 2 && c == 1) || (p == 1 && c == 0);
  endfunction

  function automatic void model_step(logic [7:0] b, bit clr);
    int cur[4];
    int cand_code[$];
    int cand_dir[$];
    int nonred, illegal, starts, best_code, best_dir, first_lit;
    nonred = 0; illegal = 0; starts = 0; first_lit = -1;
    for (int d = 0; d < 4; d++) begin
      cur[d] = (int'(b) >> (2 * d)) & 3;
      if (cur[d] != 0) begin
        nonred++;
        if (first_lit < 0) first_lit = d;
      end
      if (cur[d] == 3) illegal++;
    end
    // Collect every violation as a (class, direction) pair, then pick the smallest.
    for (int d = 0; d < 4; d++) begin
      if (cur[d] == 3) begin cand_code.push_back(1); cand_dir.push_back(d); end
      if (nonred >= 2 && cur[d] != 0) begin cand_code.push_back(2); cand_dir.push_back(d); end
      if (!legal_move(m_prev[d], cur[d])) begin cand_code.push_back(3); cand_dir.push_back(d); end
      if (m_prev[d] == 2 && cur[d] == 1 && m_run[d] < MIN_GREEN) begin cand_code.push_back(4); cand_dir.push_back(d); end
      if (m_prev[d] == 1 && cur[d] == 0 && m_run[d] < MIN_YELLOW) begin cand_code.push_back(5); cand_dir.push_back(d); end
      if (m_prev[d] == 0 && cur[d] == 2) begin
        starts++;
        if (m_allred < ALL_RED_MIN) begin cand_code.push_back(6); cand_dir.push_back(d); end
      end
    end
    best_code = 0; best_dir = 0;
    foreach (cand_code[i]) begin
      if (best_code == 0 || cand_code[i] < best_code ||
          (cand_code[i] == best_code && cand_dir[i] < best_dir)) begin
        best_code = cand_code[i];
        best_dir  = cand_dir[i];
      end
    end
    if (best_code != 0 && (m_fault == 0 || clr)) begin
      m_fault = 1; m_code = best_code; m_dir = best_dir;
    end else if (clr) begin
      m_fault = 0; m_code = 0; m_dir = 0;
    end
    if (nonred == 1 && illegal == 0) begin
      m_avalid = 1; m_adir = first_lit;
    end else begin
      m_avalid = 0;
    end
    m_phase = (m_phase + starts > SAT) ? SAT : m_phase + starts;
    m_allred = (b == 8'h00) ? ((m_allred >= SAT) ? SAT : m_allred + 1) : 0;
    for (int d = 0; d < 4; d++) begin
      if (cur[d] == m_prev[d]) m_run[d] = (m_run[d] >= SAT) ? SAT : m_run[d] + 1;
      else                     m_run[d] = 1;
      m_prev[d] = cur[d];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fault",        32'(fault),        32'(m_fault));
    chk("fault_code",   32'(fault_code),   32'(m_code));
    chk("fault_dir",    32'(fault_dir),    32'(m_dir));
    chk("active_valid", 32'(active_valid), 32'(m_avalid));
    chk("active_dir",   32'(active_dir),   32'(m_adir));
    chk("phase_count",  32'(phase_count),  32'(m_phase));
  endtask

  // Apply one bus sample for one edge, advance the model, compare 1 ns later.
  task automatic step(input logic [7:0] b, input bit clr = 1'b0, input bit do_rst = 1'b0);
    bus       = b;
    fault_clr = clr;
    rst       = do_rst;
    @(posedge clk);
    #1;
    if (do_rst) model_reset();
    else        model_step(b, clr);
    check_all();
    fault_clr = 1'b0;
    rst       = 1'b0;
  endtask

  function automatic logic [7:0] legal_next(logic [7:0] p);
    int c;
    if (p == 8'h00) return 8'(2 << (2 * $urandom_range(0, 3)));
    for (int d = 0; d < 4; d++) begin
      c = (int'(p) >> (2 * d)) & 3;
      if (c == 2) return 8'(1 << (2 * d));
      if (c == 1) return 8'h00;
    end
    return 8'h00;
  endfunction

  initial begin
    logic [7:0] pat;
    int r;
    bit clr;
    model_reset();

    // Reset state
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("rst.fault", 32'(fault), 32'd0);
    chk("rst.phase", 32'(phase_count), 32'd0);

    // Legal cycle N then S
    step(8'h00);
    repeat (4) step(8'h02);
    repeat (2) step(8'h01);
    step(8'h00);
    repeat (4) begin
      step(8'h08);
      chk("legal.active_dir", 32'(active_dir), 32'd1);
      chk("legal.active_valid", 32'(active_valid), 32'd1);
      chk("legal.fault", 32'(fault), 32'd0);
    end
    chk("legal.phase", 32'(phase_count), 32'd2);

    // Conflict, then sticky
    step(8'h0A);
    chk("conflict.fault", 32'(fault), 32'd1);
    chk("conflict.code", 32'(fault_code), 32'd2);
    chk("conflict.dir", 32'(fault_dir), 32'd0);
    step(8'hC0);
    chk("sticky.code", 32'(fault_code), 32'd2);

    // Short green, then clear after clean all-red
    step(8'h00);
    step(8'h00, 1'b1);
    chk("clr1.fault", 32'(fault), 32'd0);
    repeat (2) step(8'h02);
    step(8'h01);
    chk("short_green.code", 32'(fault_code), 32'd4);
    chk("short_green.dir", 32'(fault_dir), 32'd0);
    step(8'h00);
    step(8'h00, 1'b1);
    step(8'h00);
    chk("clr2.fault", 32'(fault), 32'd0);

    // Skipped yellow on E
    repeat (5) step(8'h20);
    step(8'h00);
    chk("skip_yellow.code", 32'(fault_code), 32'd3);
    chk("skip_yellow.dir", 32'(fault_dir), 32'd2);

    // Illegal outranks conflict
    step(8'h00, 1'b1);
    chk("clr3.fault", 32'(fault), 32'd0);
    step(8'hC2);
    chk("illegal.code", 32'(fault_code), 32'd1);
    chk("illegal.dir", 32'(fault_dir), 32'd3);

    // Reset mid-yellow, then green straight away
    step(8'h01);
    step(8'h01, 1'b0, 1'b1);
    step(8'h02);
    chk("rst_yellow.fault", 32'(fault), 32'd0);
    chk("rst_yellow.phase", 32'(phase_count), 32'd1);

    // Clear and new violation on the same sample
    step(8'hC0);
    chk("pre_clr.code", 32'(fault_code), 32'd1);
    step(8'h0A, 1'b1);
    chk("clr_viol.fault", 32'(fault), 32'd1);
    chk("clr_viol.code", 32'(fault_code), 32'd2);
    chk("clr_viol.dir", 32'(fault_dir), 32'd0);

    // Biased random traffic: mostly holds and legal advances, some corruption
    step(8'h00, 1'b0, 1'b1);
    pat = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(pat, 1'b0, 1'b1);
      end else begin
        if (r < 60)      pat = pat;
        else if (r < 88) pat = legal_next(pat);
        else if (r < 96) pat = 8'($urandom_range(0, 255));
        else             pat = pat ^ 8'(3 << (2 * $urandom_range(0, 3)));
        clr = ($urandom_range(0, 99) < 4);
        step(pat, clr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
